// File: rtl/spi_controller_if.sv
// Request/response and SPI pin bundle for spi_controller.
// master: the controller itself; slave: the requester plus the far end of the SPI link.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  modport master (
    input  req_valid, req_write, req_addr, req_data, cipo,
    output req_ready, sclk, copi, ncs, rd_data, busy, done
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, cipo,
    input  req_ready, sclk, copi, ncs, rd_data, busy, done
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 controller: sends one 16-bit frame {rw, addr, data} MSB first
// with programmable setup/hold/gap timing and captures the last 8 CIPO bits.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.master bus
);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_controller: CLK_DIV must be >= 2");
    end
    if (CS_SETUP < 1) begin : g_bad_cs_setup
      $error("spi_controller: CS_SETUP must be >= 1");
    end
    if (CS_HOLD < 1) begin : g_bad_cs_hold
      $error("spi_controller: CS_HOLD must be >= 1");
    end
    if (IDLE_GAP < 1) begin : g_bad_idle_gap
      $error("spi_controller: IDLE_GAP must be >= 1");
    end
  endgenerate

  localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B   = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
  localparam int unsigned MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  // Phase counter is loaded with N-1 on entry and the phase ends when it reaches zero.
  localparam logic [CNT_W-1:0] LD_DIV   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic [15:0]      r_shift, w_shift_nxt;
  logic [7:0]       r_rx, w_rx_nxt;
  logic [7:0]       r_rd_data, w_rd_data_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_copi, w_copi_nxt;
  logic             r_ncs, w_ncs_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ready, w_ready_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_rx_nxt      = r_rx;
    w_rd_data_nxt = r_rd_data;
    w_sclk_nxt    = r_sclk;
    w_copi_nxt    = r_copi;
    w_ncs_nxt     = r_ncs;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = LD_SETUP;
          w_bit_nxt   = '0;
          w_shift_nxt = {bus.req_write, bus.req_addr, bus.req_data};
          w_copi_nxt  = bus.req_write;
          w_ncs_nxt   = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end

      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_SHIFT;
          w_sclk_nxt  = 1'b1;
          w_cnt_nxt   = LD_DIV;
          w_rx_nxt    = {r_rx[6:0], bus.cipo};
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_SHIFT: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_sclk) begin
          w_sclk_nxt = 1'b0;
          if (r_bit == 4'd15) begin
            // Last high half: copi keeps bit 0 through HOLD.
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = LD_HOLD;
            w_bit_nxt   = '0;
          end else begin
            w_cnt_nxt   = LD_DIV;
            w_shift_nxt = {r_shift[14:0], 1'b0};
            w_copi_nxt  = r_shift[14];
            w_bit_nxt   = r_bit + 1'b1;
          end
        end else begin
          w_sclk_nxt = 1'b1;
          w_cnt_nxt  = LD_DIV;
          w_rx_nxt   = {r_rx[6:0], bus.cipo};
        end
      end

      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt   = S_GAP;
          w_cnt_nxt     = LD_GAP;
          w_ncs_nxt     = 1'b1;
          w_copi_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rd_data_nxt = r_rx;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_ncs_nxt   = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_copi_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_sclk    <= 1'b0;
      r_copi    <= 1'b0;
      r_ncs     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_rx      <= w_rx_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_copi    <= w_copi_nxt;
      r_ncs     <= w_ncs_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.sclk      = r_sclk;
  assign bus.copi      = r_copi;
  assign bus.ncs       = r_ncs;
  assign bus.rd_data   = r_rd_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
